// File: rtl/xor_begin_perm_pkg.sv
// xor_begin_perm_pkg: shared types for the ASCON entry-side XOR stage.
//   type_state  : five 64-bit lanes x0..x4, index 0 is x0
//   DATA_W      : data block width (64)
//   buf_state_t : input buffer occupancy
//   out_state_t : cipher output slot occupancy
package xor_begin_perm_pkg;
   localparam int DATA_W = 64;
   typedef logic [4:0][DATA_W-1:0] type_state;
   typedef enum logic {EMPTY, FULL} buf_state_t;
   typedef enum logic {IDLE, VALID} out_state_t;
endpackage

// File: rtl/xor_begin_perm_if.sv
// xor_begin_perm_if: data input and cipher output handshakes of xor_begin_perm.
//   data_i/data_valid_i/data_ready_o       : block into the input buffer
//   cipher_o/cipher_valid_o/cipher_ready_i : registered ciphertext word out
//   master: the environment side, slave: the xor_begin_perm side
interface xor_begin_perm_if
   import xor_begin_perm_pkg::*;
();
   logic [DATA_W-1:0] data_i;
   logic              data_valid_i;
   logic              data_ready_o;
   logic [DATA_W-1:0] cipher_o;
   logic              cipher_valid_o;
   logic              cipher_ready_i;
   modport master (
      output data_i, data_valid_i, cipher_ready_i,
      input  data_ready_o, cipher_o, cipher_valid_o
   );
   modport slave (
      input  data_i, data_valid_i, cipher_ready_i,
      output data_ready_o, cipher_o, cipher_valid_o
   );
endinterface

// File: rtl/xor_begin_perm_skid_reg64.sv
// xor_begin_perm_skid_reg64: single 64-bit register slot with valid/ready on both sides.
//   clock_i, reset_i (async, active-high)
//   in_valid_i/in_data_i/in_ready_o    : write side; ready when empty or being drained
//   out_data_o/out_valid_o/out_ready_i : read side; data held stable while not accepted
module xor_begin_perm_skid_reg64
   import xor_begin_perm_pkg::*;
(
   input  logic        clock_i,
   input  logic        reset_i,
   input  logic        in_valid_i,
   input  logic [63:0] in_data_i,
   output logic        in_ready_o,
   output logic [63:0] out_data_o,
   output logic        out_valid_o,
   input  logic        out_ready_i
);
   out_state_t  state_q, state_d;
   logic [63:0] data_q, data_d;
   logic        load;
   assign in_ready_o  = (state_q == IDLE) | out_ready_i;
   assign load        = in_valid_i & in_ready_o;
   assign out_valid_o = (state_q == VALID);
   assign out_data_o  = data_q;
   always_comb begin
      state_d = load ? VALID : (out_ready_i ? IDLE : state_q);
      data_d  = load ? in_data_i : data_q;
   end
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
      end
   end
endmodule

// File: rtl/xor_begin_perm.sv
// xor_begin_perm: buffers one data block and XORs it into x0 (and the key into x1/x2) at permutation entry.
//   clock_i, reset_i (async, active-high)
//   bus (xor_begin_perm_if.slave) : data_i handshake in, cipher_o handshake out
//   en_xor_data_i : consume the buffer into x0 (only when it is full)
//   en_cipher_i   : also capture the new x0 as a ciphertext word
//   en_xor_key_i  : XOR key_i into {x1,x2}
//   registerS_i/registerS_o : state in, state after XOR (combinational)
//   underflow_o / overflow_o : sticky error flags
//   Optional macro XOR_BEGIN_BLOCK_CNT_EN adds block_cnt_o, a saturating consume counter.
module xor_begin_perm
   import xor_begin_perm_pkg::*;
#(
   parameter int DATA_W = 64
`ifdef XOR_BEGIN_BLOCK_CNT_EN
   , parameter int CNT_W = 8
`endif
) (
   input  logic              clock_i,
   input  logic              reset_i,
   xor_begin_perm_if.slave   bus,
   input  logic              en_xor_data_i,
   input  logic              en_cipher_i,
   input  logic              en_xor_key_i,
   input  logic [127:0]      key_i,
   input  type_state         registerS_i,
   output type_state         registerS_o,
   output logic              underflow_o,
   output logic              overflow_o
`ifdef XOR_BEGIN_BLOCK_CNT_EN
   , output logic [CNT_W-1:0] block_cnt_o
`endif
);
   buf_state_t        state_q, state_d;
   logic [DATA_W-1:0] buf_q, buf_d;
   logic              underflow_q, underflow_d;
   logic              overflow_q, overflow_d;
   logic              load, consume, capture, cap_ready;
   assign load    = (state_q == EMPTY) & bus.data_valid_i;
   assign consume = (state_q == FULL) & en_xor_data_i;
   assign capture = consume & en_cipher_i;
   // Ready is forced low during reset so no block is offered into a clearing buffer.
   assign bus.data_ready_o = (state_q == EMPTY) & ~reset_i;
   assign registerS_o[0] = registerS_i[0] ^ (consume ? buf_q : '0);
   assign {registerS_o[1], registerS_o[2]} = {registerS_i[1], registerS_i[2]} ^ (en_xor_key_i ? key_i : '0);
   assign registerS_o[4:3] = registerS_i[4:3];
   assign underflow_o = underflow_q;
   assign overflow_o  = overflow_q;
   always_comb begin
      state_d     = (state_q == EMPTY) ? (bus.data_valid_i ? FULL : EMPTY) : (en_xor_data_i ? EMPTY : FULL);
      buf_d       = load ? bus.data_i : buf_q;
      underflow_d = underflow_q | ((state_q == EMPTY) & en_xor_data_i);
      overflow_d  = overflow_q | (capture & ~cap_ready);
   end
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
         state_q     <= EMPTY;
         buf_q       <= '0;
         underflow_q <= 1'b0;
         overflow_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         underflow_q <= underflow_d;
         overflow_q  <= overflow_d;
      end
   end
   xor_begin_perm_skid_reg64 u_cipher (
      .clock_i     (clock_i),
      .reset_i     (reset_i),
      .in_valid_i  (capture),
      .in_data_i   (registerS_o[0]),
      .in_ready_o  (cap_ready),
      .out_data_o  (bus.cipher_o),
      .out_valid_o (bus.cipher_valid_o),
      .out_ready_i (bus.cipher_ready_i)
   );
`ifdef XOR_BEGIN_BLOCK_CNT_EN
   logic [CNT_W-1:0] cnt_q, cnt_d;
   // Key XOR marks finalization, so the count restarts for the next message.
   always_comb begin
      cnt_d = en_xor_key_i ? '0 : ((consume & ~&cnt_q) ? cnt_q + CNT_W'(1) : cnt_q);
   end
   always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) cnt_q <= '0;
      else cnt_q <= cnt_d;
   end
   assign block_cnt_o = cnt_q;
`endif
endmodule

// File: tb/tb_xor_begin_perm.sv
// tb_xor_begin_perm: table-driven and scoreboard checks of xor_begin_perm.
module tb_xor_begin_perm;
   import xor_begin_perm_pkg::*;
   logic         clock_i = 1'b0;
   logic         reset_i = 1'b1;
   logic         en_xor_data_i = 1'b0;
   logic         en_cipher_i = 1'b0;
   logic         en_xor_key_i = 1'b0;
   logic [127:0] key_i = '0;
   type_state    registerS_i = '0;
   type_state    registerS_o;
   logic         underflow_o, overflow_o;
`ifdef XOR_BEGIN_BLOCK_CNT_EN
   logic [7:0]   block_cnt_o;
`endif
   xor_begin_perm_if bus();
   xor_begin_perm dut (
      .clock_i       (clock_i),
      .reset_i       (reset_i),
      .bus           (bus),
      .en_xor_data_i (en_xor_data_i),
      .en_cipher_i   (en_cipher_i),
      .en_xor_key_i  (en_xor_key_i),
      .key_i         (key_i),
      .registerS_i   (registerS_i),
      .registerS_o   (registerS_o),
      .underflow_o   (underflow_o),
      .overflow_o    (overflow_o)
`ifdef XOR_BEGIN_BLOCK_CNT_EN
      , .block_cnt_o (block_cnt_o)
`endif
   );
   always #5 clock_i = ~clock_i;
   int n_checks = 0;
   int n_fail = 0;
   logic [63:0] sb[$];
   logic [63:0] last_d;
   task automatic check(input string name, input logic [319:0] act, input logic [319:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask
   always @(negedge clock_i) begin
      if (!reset_i && bus.cipher_valid_o && bus.cipher_ready_i) begin
         if (sb.size() == 0) check("sb_unexpected_word", {256'd0, bus.cipher_o}, 320'd0);
         else check("sb_cipher", {256'd0, bus.cipher_o}, {256'd0, sb.pop_front()});
      end
   end
   initial begin
      #1000000;
      $display("FAIL timeout: simulation time limit reached");
      $fatal(1, "timeout");
   end
   typedef struct {
      logic         load;
      logic [63:0]  data;
      logic         en_d, en_k, en_c;
      logic [127:0] key;
      type_state    s_in;
      type_state    s_exp;
   } vec_t;
   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction
   function automatic type_state rst();
      type_state s;
      for (int i = 0; i < 5; i++) s[i] = r64();
      return s;
   endfunction
   function automatic vec_t mk(input logic ld, input logic [63:0] d, input logic ed, input logic ek,
                               input logic ec, input logic [127:0] k, input type_state s);
      vec_t v;
      v.load = ld; v.data = d; v.en_d = ed; v.en_k = ek; v.en_c = ec; v.key = k; v.s_in = s;
      v.s_exp = s;
      if (ld && ed) v.s_exp[0] = s[0] ^ d;
      if (ek) begin
         v.s_exp[1] = s[1] ^ k[127:64];
         v.s_exp[2] = s[2] ^ k[63:0];
      end
      return v;
   endfunction
   task automatic tick();
      @(posedge clock_i);
      #1;
   endtask
   task automatic load(input logic [63:0] d);
      bus.data_i = d;
      bus.data_valid_i = 1'b1;
      last_d = d;
      tick();
      bus.data_valid_i = 1'b0;
   endtask
   task automatic consume(input logic [63:0] x0, input logic cap);
      en_xor_data_i = 1'b1;
      en_cipher_i = cap;
      registerS_i[0] = x0;
      tick();
      en_xor_data_i = 1'b0;
      en_cipher_i = 1'b0;
   endtask
   vec_t tbl[8];
   type_state s;
   logic [63:0] w, w3, x;
   initial begin
      bus.data_i = '0;
      bus.data_valid_i = 1'b0;
      bus.cipher_ready_i = 1'b1;
      s = rst(); s[0] = 64'hFFFF0000FFFF0000;
      tbl[0] = mk(1, 64'h0123456789ABCDEF, 1, 0, 0, '0, s);
      s = rst(); s[1] = '0; s[2] = '0;
      tbl[1] = mk(0, '0, 0, 1, 0, 128'h000102030405060708090A0B0C0D0E0F, s);
      tbl[2] = mk(1, r64(), 1, 1, 0, {r64(), r64()}, rst());
      tbl[3] = mk(1, r64(), 1, 0, 1, '0, rst());
      tbl[4] = mk(0, '0, 0, 0, 0, {r64(), r64()}, rst());
      tbl[5] = mk(1, r64(), 1, 1, 1, {r64(), r64()}, rst());
      tbl[6] = mk(0, '0, 0, 1, 0, {r64(), r64()}, rst());
      tbl[7] = mk(1, 64'hFFFFFFFFFFFFFFFF, 1, 0, 0, '0, rst());
      #3;
      check("reset_ready_low", {319'd0, bus.data_ready_o}, 320'd0);
      check("reset_valid_low", {319'd0, bus.cipher_valid_o}, 320'd0);
      @(posedge clock_i);
      #1 reset_i = 1'b0;
      #1;
      check("reset_ready_high", {319'd0, bus.data_ready_o}, 320'd1);
      check("reset_cipher_zero", {256'd0, bus.cipher_o}, 320'd0);
      check("reset_flags", {318'd0, underflow_o, overflow_o}, 320'd0);
      tick();
      for (int i = 0; i < 8; i++) begin
         if (tbl[i].load) begin
            load(tbl[i].data);
            check($sformatf("vec%0d_ready_full", i), {319'd0, bus.data_ready_o}, 320'd0);
         end
         en_xor_data_i = tbl[i].en_d;
         en_xor_key_i = tbl[i].en_k;
         en_cipher_i = tbl[i].en_c;
         key_i = tbl[i].key;
         registerS_i = tbl[i].s_in;
         #1;
         check($sformatf("vec%0d_state", i), registerS_o, tbl[i].s_exp);
         if (tbl[i].load && tbl[i].en_d && tbl[i].en_c) sb.push_back(tbl[i].s_exp[0]);
         tick();
         en_xor_data_i = 1'b0; en_xor_key_i = 1'b0; en_cipher_i = 1'b0;
         check($sformatf("vec%0d_ready_empty", i), {319'd0, bus.data_ready_o}, 320'd1);
      end
      tick();
      // hold: cipher word stays while downstream stalls
      bus.cipher_ready_i = 1'b0;
      load(64'h0123456789ABCDEF);
      en_xor_data_i = 1'b1; en_cipher_i = 1'b1; registerS_i[0] = 64'hFFFF0000FFFF0000;
      #1;
      check("hold_x0", {256'd0, registerS_o[0]}, {256'd0, 64'hFEDC45677654CDEF});
      sb.push_back(64'hFEDC45677654CDEF);
      tick();
      en_xor_data_i = 1'b0; en_cipher_i = 1'b0;
      check("hold_ready", {319'd0, bus.data_ready_o}, 320'd1);
      for (int i = 0; i < 5; i++) begin
         check("hold_valid", {319'd0, bus.cipher_valid_o}, 320'd1);
         check("hold_cipher", {256'd0, bus.cipher_o}, {256'd0, 64'hFEDC45677654CDEF});
         tick();
      end
      bus.cipher_ready_i = 1'b1;
      tick();
      bus.cipher_ready_i = 1'b0;
      check("hold_valid_drop", {319'd0, bus.cipher_valid_o}, 320'd0);
      // replace: capture while the old word drains in the same cycle
      x = r64(); load(r64()); w = x ^ last_d;
      consume(x, 1'b1); sb.push_back(w);
      x = r64(); load(r64()); w3 = x ^ last_d;
      bus.cipher_ready_i = 1'b1;
      consume(x, 1'b1); sb.push_back(w3);
      bus.cipher_ready_i = 1'b0;
      check("replace_valid", {319'd0, bus.cipher_valid_o}, 320'd1);
      check("replace_cipher", {256'd0, bus.cipher_o}, {256'd0, w3});
      check("replace_no_overflow", {319'd0, overflow_o}, 320'd0);
      // overflow: capture while stalled keeps the old word
      x = r64(); load(r64());
      consume(x, 1'b1);
      check("ovf_flag", {319'd0, overflow_o}, 320'd1);
      check("ovf_cipher_kept", {256'd0, bus.cipher_o}, {256'd0, w3});
      bus.cipher_ready_i = 1'b1;
      tick();
      bus.cipher_ready_i = 1'b0;
      check("ovf_valid_drop", {319'd0, bus.cipher_valid_o}, 320'd0);
      check("ovf_sticky", {319'd0, overflow_o}, 320'd1);
      // underflow: consume from an empty buffer
      s = rst();
      registerS_i = s;
      en_xor_data_i = 1'b1; en_cipher_i = 1'b1;
      #1;
      check("unf_passthrough", {256'd0, registerS_o[0]}, {256'd0, s[0]});
      tick();
      en_xor_data_i = 1'b0; en_cipher_i = 1'b0;
      check("unf_no_capture", {319'd0, bus.cipher_valid_o}, 320'd0);
      check("unf_flag", {319'd0, underflow_o}, 320'd1);
      repeat (3) tick();
      check("unf_sticky", {319'd0, underflow_o}, 320'd1);
      // async reset with buffer FULL and cipher VALID
      load(r64());
      consume(r64(), 1'b1);
      load(r64());
      check("pre_rst_full", {318'd0, bus.data_ready_o, bus.cipher_valid_o}, 320'd1);
      #3 reset_i = 1'b1;
      #1;
      check("rst_ready_low", {319'd0, bus.data_ready_o}, 320'd0);
      check("rst_valid_low", {319'd0, bus.cipher_valid_o}, 320'd0);
      check("rst_flags_clear", {318'd0, underflow_o, overflow_o}, 320'd0);
      #2 reset_i = 1'b0;
      tick();
      check("post_rst_ready", {319'd0, bus.data_ready_o}, 320'd1);
      check("post_rst_cipher", {256'd0, bus.cipher_o}, 320'd0);
`ifdef XOR_BEGIN_BLOCK_CNT_EN
      check("cnt_reset", {312'd0, block_cnt_o}, 320'd0);
      for (int i = 0; i < 300; i++) begin
         load(r64());
         consume(r64(), 1'b0);
      end
      check("cnt_saturate", {312'd0, block_cnt_o}, 320'd255);
      en_xor_key_i = 1'b1;
      tick();
      en_xor_key_i = 1'b0;
      check("cnt_key_clear", {312'd0, block_cnt_o}, 320'd0);
`endif
      check("sb_drained", {288'd0, 32'(sb.size())}, 320'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
